// File: rtl/neokeon_pkg.sv
// Shared Neokeon definitions: round-constant table, word-slice view of the state, and rotations.
// Pulled in by both the Theta/Pi1 stage and the Theta combinational block.
package neokeon_pkg;

   typedef logic [31:0] word_t;

   // Index 0 is the most significant word, so a0 = [127:96] ... a3 = [31:0].
   typedef word_t [0:3] state_words_t;

   localparam int unsigned RC_COUNT = 17;

   localparam logic [7:0] RC_TABLE [RC_COUNT] = '{
      8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
      8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4
   };

   // Indices beyond the table return zero, so such rounds behave as if no constant is added.
   function automatic logic [7:0] rc_lookup(input logic [4:0] round);
      if (round < 5'd17) return RC_TABLE[round];
      return 8'h00;
   endfunction

   function automatic word_t rotl32(input word_t x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic word_t rotr32(input word_t x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t thetaMix(input word_t t);
      return t ^ rotl32(t, 8) ^ rotr32(t, 8);
   endfunction

endpackage

// File: rtl/neokeon_theta.sv
// Combinational Neokeon Theta(state, key). No clock; also usable by a decrypt key-schedule path.
import neokeon_pkg::*;

module neokeon_theta (
   input  logic [127:0] stateIn,
   input  logic [127:0] keyIn,
   output logic [127:0] stateOut
);

   state_words_t a;
   state_words_t k;
   word_t        t1;
   word_t        t2;

   always_comb begin
      a  = stateIn;
      k  = keyIn;
      t1 = thetaMix(a[0] ^ a[2]);
      a[1] = a[1] ^ t1;
      a[3] = a[3] ^ t1;
      a  = a ^ k;
      t2 = thetaMix(a[1] ^ a[3]);
      a[0] = a[0] ^ t2;
      a[2] = a[2] ^ t2;
      stateOut = a;
   end

endmodule

// File: rtl/neokeon_theta_pi1_stage.sv
// Noekeon round front half (RC add, Theta, Pi1) into a two-entry elastic output buffer.
// Optional NEOKEON_DECRYPT_EN adds in_dec/out_dec and the decrypt ordering (Theta before RC).
import neokeon_pkg::*;

module neokeon_theta_pi1_stage (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic [127:0] in_key,
   input  logic [4:0]   in_round,
`ifdef NEOKEON_DECRYPT_EN
   input  logic         in_dec,
   output logic         out_dec,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic [4:0]   out_round
);

   typedef struct packed {
`ifdef NEOKEON_DECRYPT_EN
      logic         dec;
`endif
      logic [4:0]   round;
      logic [127:0] state;
   } stage_word_t;

   logic         isDec;
   word_t        rcWord;
   state_words_t preTheta;
   logic [127:0] postTheta;
   state_words_t mixed;
   state_words_t piOut;

   stage_word_t  newWord;
   stage_word_t  mWord;
   stage_word_t  sWord;
   logic         mValid;
   logic         sValid;
   logic         accept;
   logic         pop;

`ifdef NEOKEON_DECRYPT_EN
   assign isDec = in_dec;
`else
   assign isDec = 1'b0;
`endif

   assign rcWord = {24'h000000, rc_lookup(in_round)};

   // One Theta instance serves both orderings; RC is added before it (encrypt) or after it (decrypt).
   always_comb begin
      preTheta = in_state;
      if (!isDec) preTheta[0] = preTheta[0] ^ rcWord;
   end

   neokeon_theta uTheta (
      .stateIn  (preTheta),
      .keyIn    (in_key),
      .stateOut (postTheta)
   );

   always_comb begin
      mixed = postTheta;
      if (isDec) mixed[0] = mixed[0] ^ rcWord;
      piOut[0] = mixed[0];
      piOut[1] = rotl32(mixed[1], 1);
      piOut[2] = rotl32(mixed[2], 5);
      piOut[3] = rotl32(mixed[3], 2);
   end

   always_comb begin
      newWord       = '0;
      newWord.state = piOut;
      newWord.round = in_round;
`ifdef NEOKEON_DECRYPT_EN
      newWord.dec   = in_dec;
`endif
   end

   assign accept = in_valid && !sValid;
   assign pop    = mValid && out_ready;

   // S only fills when M is occupied and not draining, so it always holds the younger word.
   always_ff @(posedge clk) begin
      if (rst) begin
         mValid <= 1'b0;
         sValid <= 1'b0;
         mWord  <= '0;
         sWord  <= '0;
      end else if (pop && sValid) begin
         mWord  <= sWord;
         sValid <= 1'b0;
      end else if (accept && (!mValid || pop)) begin
         mWord  <= newWord;
         mValid <= 1'b1;
      end else if (accept) begin
         sWord  <= newWord;
         sValid <= 1'b1;
      end else if (pop) begin
         mValid <= 1'b0;
      end
   end

   assign in_ready  = !sValid;
   assign out_valid = mValid;
   assign out_state = mWord.state;
   assign out_round = mWord.round;
`ifdef NEOKEON_DECRYPT_EN
   assign out_dec   = mWord.dec;
`endif

endmodule

// File: tb/tb_neokeon_theta_pi1_stage.sv
// Self-checking bench for neokeon_theta_pi1_stage: directed vectors, backpressure/reset sequences,
// and randomized traffic against a word-array reference model. Honors NEOKEON_DECRYPT_EN.
module tb_neokeon_theta_pi1_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [127:0] in_key;
   logic [4:0]   in_round;
   logic         inDec;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic [4:0]   out_round;
   logic         outDec;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   neokeon_theta_pi1_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_key    (in_key),
      .in_round  (in_round),
`ifdef NEOKEON_DECRYPT_EN
      .in_dec    (inDec),
      .out_dec   (outDec),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .out_round (out_round)
   );

`ifndef NEOKEON_DECRYPT_EN
   assign outDec = 1'b0;
`endif

   logic [7:0] tbRc [17] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
                             8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};

   function automatic logic [7:0] rcOf(input logic [4:0] r);
      if (r <= 5'd16) return tbRc[r];
      return 8'h00;
   endfunction

   // Bitwise rotation: bit i moves to position (i+n) mod 32.
   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[5'((i + n) % 32)] = x[i];
      return r;
   endfunction

   function automatic logic [127:0] refModel(input logic [127:0] st, input logic [127:0] key,
                                             input logic [7:0] rc, input logic dec);
      logic [31:0] a [4];
      logic [31:0] k [4];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) begin
         a[i] = st[127 - 32*i -: 32];
         k[i] = key[127 - 32*i -: 32];
      end
      if (!dec) a[0] = a[0] ^ {24'd0, rc};
      t = a[0] ^ a[2];
      t = t ^ rl(t, 8) ^ rl(t, 24);
      a[1] = a[1] ^ t;
      a[3] = a[3] ^ t;
      for (int i = 0; i < 4; i++) a[i] = a[i] ^ k[i];
      t = a[1] ^ a[3];
      t = t ^ rl(t, 8) ^ rl(t, 24);
      a[0] = a[0] ^ t;
      a[2] = a[2] ^ t;
      if (dec) a[0] = a[0] ^ {24'd0, rc};
      return {a[0], rl(a[1], 1), rl(a[2], 5), rl(a[3], 2)};
   endfunction

   function automatic logic pickDec();
`ifdef NEOKEON_DECRYPT_EN
      return 1'($urandom_range(0, 1));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual %h, required %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [127:0] st;
      logic [4:0]   rnd;
      logic         dec;
   } exp_t;

   exp_t curExp;
   exp_t expQ [$];

   task automatic randomInputs();
      in_state = rand128();
      in_key   = rand128();
      in_round = 5'($urandom_range(0, 31));
      inDec    = pickDec();
      curExp.st  = refModel(in_state, in_key, rcOf(in_round), inDec);
      curExp.rnd = in_round;
      curExp.dec = inDec;
   endtask

   // Called between edges: scores a pop and records an accept for the coming edge, then advances.
   task automatic scoreCycle();
      exp_t e;
      if (out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            chk("unexpected_output", 128'(out_valid), 128'd0);
         end else begin
            e = expQ.pop_front();
            chk("stream_state", out_state, e.st);
            chk("stream_round", 128'(out_round), 128'(e.rnd));
            chk("stream_dec", 128'(outDec), 128'(e.dec));
         end
      end
      if (in_valid && in_ready) expQ.push_back(curExp);
      step();
   endtask

   typedef struct {
      logic [127:0] st;
      logic [127:0] key;
      logic [4:0]   rnd;
      logic         dec;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [$];

   initial begin
      vec_t v;
      exp_t e0;
      exp_t e1;
      logic sawValid;

      // Directed table.
      v = '{st: '0, key: '0, rnd: 5'd0, dec: 1'b0,
            exp: 128'h00000080_00010101_00000000_00020202};
      vecs.push_back(v);
      v.st = rand128(); v.key = rand128(); v.rnd = 5'd20; v.dec = 1'b0;
      v.exp = refModel(v.st, v.key, 8'h00, 1'b0);
      vecs.push_back(v);
      v.st = rand128(); v.key = rand128(); v.rnd = 5'd16; v.dec = 1'b0;
      v.exp = refModel(v.st, v.key, 8'hD4, 1'b0);
      vecs.push_back(v);
      v.st = rand128(); v.key = rand128(); v.rnd = 5'd17; v.dec = 1'b0;
      v.exp = refModel(v.st, v.key, 8'h00, 1'b0);
      vecs.push_back(v);
      v.st = rand128(); v.key = rand128(); v.rnd = 5'd5; v.dec = 1'b0;
      v.exp = refModel(v.st, v.key, 8'hAB, 1'b0);
      vecs.push_back(v);
`ifdef NEOKEON_DECRYPT_EN
      v = '{st: '0, key: '0, rnd: 5'd0, dec: 1'b1,
            exp: 128'h00000080_00000000_00000000_00000000};
      vecs.push_back(v);
      v.st = rand128(); v.key = rand128(); v.rnd = 5'd9; v.dec = 1'b1;
      v.exp = refModel(v.st, v.key, 8'h5E, 1'b1);
      vecs.push_back(v);
`endif

      // Reset state.
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_state = '0; in_key = '0; in_round = '0; inDec = 1'b0;
      repeat (3) step();
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_in_ready", 128'(in_ready), 128'd1);
      chk("reset_out_state", out_state, 128'd0);
      chk("reset_out_round", 128'(out_round), 128'd0);
      chk("reset_out_dec", 128'(outDec), 128'd0);
      rst = 1'b0;
      step();

      // Table vectors, one at a time: result must appear one edge after accept.
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         in_valid = 1'b1;
         in_state = vecs[i].st; in_key = vecs[i].key;
         in_round = vecs[i].rnd; inDec = vecs[i].dec;
         step();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'd1);
         chk($sformatf("vec%0d_state", i), out_state, vecs[i].exp);
         chk($sformatf("vec%0d_round", i), 128'(out_round), 128'(vecs[i].rnd));
         chk($sformatf("vec%0d_dec", i), 128'(outDec), 128'(vecs[i].dec));
         step();
         chk($sformatf("vec%0d_drained", i), 128'(out_valid), 128'd0);
      end

      // Backpressure: two words fill M and S, the third is refused, then in-order release.
      out_ready = 1'b0;
      randomInputs(); e0 = curExp; in_valid = 1'b1;
      step();
      chk("bp_m_valid", 128'(out_valid), 128'd1);
      chk("bp_m_ready", 128'(in_ready), 128'd1);
      randomInputs(); e1 = curExp;
      step();
      chk("bp_full_ready", 128'(in_ready), 128'd0);
      chk("bp_hold_state0", out_state, e0.st);
      randomInputs();
      step();
      chk("bp_third_refused", 128'(in_ready), 128'd0);
      chk("bp_hold_state1", out_state, e0.st);
      chk("bp_hold_round", 128'(out_round), 128'(e0.rnd));
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("bp_second_valid", 128'(out_valid), 128'd1);
      chk("bp_second_state", out_state, e1.st);
      chk("bp_second_ready", 128'(in_ready), 128'd1);
      step();
      chk("bp_empty", 128'(out_valid), 128'd0);

      // Streaming 20 words with no bubbles.
      out_ready = 1'b1;
      for (int w = 0; w < 20; w++) begin
         randomInputs();
         in_valid = 1'b1;
         chk("stream_in_ready", 128'(in_ready), 128'd1);
         if (w > 0) chk("stream_no_bubble", 128'(out_valid), 128'd1);
         scoreCycle();
      end
      in_valid = 1'b0;
      scoreCycle();
      chk("stream_all_out", 128'(expQ.size()), 128'd0);

      // Randomized traffic with random backpressure.
      for (int c = 0; c < 300; c++) begin
         randomInputs();
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 3) != 0);
         scoreCycle();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 10 && (expQ.size() != 0 || out_valid); c++) scoreCycle();
      chk("random_drained_queue", 128'(expQ.size()), 128'd0);
      chk("random_drained_valid", 128'(out_valid), 128'd0);

      // Reset with both buffers full drops everything.
      out_ready = 1'b0;
      randomInputs(); in_valid = 1'b1;
      step();
      randomInputs();
      step();
      chk("rstfull_ready", 128'(in_ready), 128'd0);
      chk("rstfull_valid", 128'(out_valid), 128'd1);
      rst = 1'b1; in_valid = 1'b0;
      step();
      chk("rstmid_valid", 128'(out_valid), 128'd0);
      chk("rstmid_ready", 128'(in_ready), 128'd1);
      chk("rstmid_state", out_state, 128'd0);
      rst = 1'b0; out_ready = 1'b1;
      sawValid = 1'b0;
      repeat (5) begin
         step();
         if (out_valid) sawValid = 1'b1;
      end
      chk("rstmid_no_stale", 128'(sawValid), 128'd0);
      chk("rstmid_ready_after", 128'(in_ready), 128'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
